// File: rtl/s2p_framer.sv
//-----------------------------------------------------------------------------
// s2p_framer
//
// Parametrised serial-to-parallel deserializer with a valid/ack output
// handshake. Serial bits are collected while enable is high. Each completed
// frame goes to a holding register (data_out), so the next frame can be
// received while the consumer still owns the previous word. A frame that
// completes while the holding register is still unaccepted is dropped, and
// the sticky overrun flag is set.
//
// Optional feature: define S2P_PARITY_CHECK_EN to append one even-parity bit
// to every frame. parity_err is then loaded together with data_out. When the
// macro is undefined, frames carry data bits only and parity_err is tied to 0.
//
// Parameters:
//   WIDTH  maximum frame length in bits and width of data_out (2..32)
//   LEN_W  width of len / bit_cnt
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   data_in      serial bit, sampled when enable=1
//   enable       frame window; dropping it aborts a partial frame
//   len          bits per frame (0 or >WIDTH selects WIDTH)
//   msb_first    1: first bit is the MSB of the frame; 0: first bit is the LSB
//   ack          consumer accepts data_out while valid=1
//   clr_overrun  synchronous clear of overrun (a same-edge overrun wins)
//   data_out     last accepted frame, right-justified, upper bits zero
//   valid        data_out holds an unaccepted word
//   busy         a partial frame is in progress
//   bit_cnt      bits received so far in the current frame
//   overrun      sticky: a completed frame was dropped
//   parity_err   parity error of the word in data_out (qualified by valid)
//-----------------------------------------------------------------------------
module s2p_framer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             enable,
    input  logic [LEN_W-1:0] len,
    input  logic             msb_first,
    input  logic             ack,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic [LEN_W-1:0] bit_cnt,
    output logic             overrun,
    output logic             parity_err
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] sreg_base, sreg_ins, word;
    logic [LEN_W-1:0] len_q, len_nxt, cnt_nxt;
    logic [LEN_W-1:0] norm_len, cur_len;
    logic             order_q, order_nxt, cur_msb;
    logic [IDX_W-1:0] ins_idx;
    logic             data_bit, last_edge, done;
    logic [WIDTH-1:0] dout_nxt;
    logic             valid_nxt, ovr_nxt;
`ifdef S2P_PARITY_CHECK_EN
    logic             par_q, par_nxt, par_run;
    logic             perr_q, perr_nxt, perr_new;
`endif

    always_comb begin
        // NOTE: every variable gets a value before any conditional assignment,
        // so no path through this block can infer a latch.
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sreg_nxt  = sreg;
        len_nxt   = len_q;
        order_nxt = order_q;
        dout_nxt  = data_out;
        valid_nxt = valid;
        ovr_nxt   = overrun;

        // Frame configuration comes from the ports only on the first edge of a
        // frame. After that edge, the latched copy is used.
        norm_len  = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
        cur_len   = (state == IDLE) ? norm_len  : len_q;
        cur_msb   = (state == IDLE) ? msb_first : order_q;

        // The first bit of a frame is inserted into a cleared register, so
        // leftovers of an aborted frame never reach data_out.
        sreg_base = (state == IDLE) ? '0 : sreg;
        ins_idx   = bit_cnt[IDX_W-1:0];
        sreg_ins  = sreg_base;
        if (cur_msb) begin
            sreg_ins = {sreg_base[WIDTH-2:0], data_in};
        end else begin
            sreg_ins[ins_idx] = data_in;
        end

`ifdef S2P_PARITY_CHECK_EN
        // The data bits occupy counts 0..eff_len-1. The parity bit arrives at
        // count eff_len and completes the frame. By then the word is already
        // complete in sreg.
        data_bit  = (bit_cnt != cur_len);
        last_edge = (bit_cnt == cur_len);
        word      = sreg;
        par_run   = ((state == IDLE) ? 1'b0 : par_q) ^ data_in;
        perr_new  = par_q ^ data_in;
        par_nxt   = par_q;
        perr_nxt  = perr_q;
`else
        data_bit  = 1'b1;
        last_edge = (bit_cnt == cur_len - LEN_W'(1));
        word      = sreg_ins;
`endif
        done = enable && last_edge;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            len_nxt   = cur_len;
            order_nxt = cur_msb;
            if (data_bit) begin
                sreg_nxt = sreg_ins;
`ifdef S2P_PARITY_CHECK_EN
                par_nxt  = par_run;
`endif
            end
            if (done) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SHIFT;
                cnt_nxt   = bit_cnt + LEN_W'(1);
            end
        end

        // Handshake. A completion takes priority over a plain ack, so an ack
        // on the completing edge hands the slot straight to the new word.
        if (clr_overrun) begin
            ovr_nxt = 1'b0;
        end
        if (valid && ack) begin
            valid_nxt = 1'b0;
        end
        if (done) begin
            if (!valid || ack) begin
                dout_nxt  = word;
                valid_nxt = 1'b1;
`ifdef S2P_PARITY_CHECK_EN
                perr_nxt  = perr_new;
`endif
            end else begin
                ovr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every register is reset, including the shift register and
            // the latched frame configuration, so no X reaches data_out or the
            // length compare.
            state    <= IDLE;
            bit_cnt  <= '0;
            sreg     <= '0;
            len_q    <= '0;
            order_q  <= 1'b0;
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
`ifdef S2P_PARITY_CHECK_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register takes the value
            // the combinational block computed from the pre-edge state.
            state    <= state_nxt;
            bit_cnt  <= cnt_nxt;
            sreg     <= sreg_nxt;
            len_q    <= len_nxt;
            order_q  <= order_nxt;
            data_out <= dout_nxt;
            valid    <= valid_nxt;
            overrun  <= ovr_nxt;
`ifdef S2P_PARITY_CHECK_EN
            par_q    <= par_nxt;
            perr_q   <= perr_nxt;
`endif
        end
    end

    assign busy = (bit_cnt != '0);

`ifdef S2P_PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_framer.sv
//-----------------------------------------------------------------------------
// tb_s2p_framer
//
// Directed bench for s2p_framer (WIDTH=16). Every frame sent produces its
// expected word. Accepted words go into a queue, and each is popped and
// compared when the DUT presents it on data_out. Frames that should be dropped
// are never queued.
//-----------------------------------------------------------------------------
module tb_s2p_framer;

    localparam int WIDTH = 16;
    localparam int LEN_W = $clog2(WIDTH) + 1;
`ifdef S2P_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             data_in;
    logic             enable;
    logic [LEN_W-1:0] len;
    logic             msb_first;
    logic             ack;
    logic             clr_overrun;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic [LEN_W-1:0] bit_cnt;
    logic             overrun;
    logic             parity_err;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    s2p_framer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .enable     (enable),
        .len        (len),
        .msb_first  (msb_first),
        .ack        (ack),
        .clr_overrun(clr_overrun),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq[0] is the first bit on the wire. len_val is driven on the len port,
    // and the task models its normalisation. With twiddle set, len and
    // msb_first change after the first edge; the model keeps the values from
    // the start of the frame.
    task automatic send_seq(input logic [31:0] seq, input int len_val, input bit msb,
                            input bit push, input bit keep_en, input bit ack_last,
                            input bit bad_par, input bit twiddle);
        int               eff;
        logic [WIDTH-1:0] w;
        exp_t             e;
`ifdef S2P_PARITY_CHECK_EN
        logic             par;
        par = 1'b0;
`endif
        eff       = (len_val == 0 || len_val > WIDTH) ? WIDTH : len_val;
        len       = LEN_W'(len_val);
        msb_first = msb;
        w         = '0;
        for (int i = 0; i < eff; i++) begin
            bit last;
            last    = !PAR_EN && (i == eff - 1);
            data_in = seq[i];
            enable  = 1'b1;
            ack     = ack_last && last;
            if (msb) w = {w[WIDTH-2:0], seq[i]};
            else     w[i] = seq[i];
`ifdef S2P_PARITY_CHECK_EN
            par ^= seq[i];
`endif
            step();
            ack = 1'b0;
            if (twiddle && i == 0) begin
                len       = LEN_W'(len_val + 4);
                msb_first = !msb;
            end
            check($sformatf("bit_cnt[%0d]", i), 32'(bit_cnt), last ? 0 : i + 1);
            check($sformatf("busy[%0d]", i), 32'(busy), last ? 0 : 1);
        end
`ifdef S2P_PARITY_CHECK_EN
        data_in = par ^ bad_par;
        ack     = ack_last;
        step();
        ack = 1'b0;
        check("bit_cnt_par", 32'(bit_cnt), 0);
        check("busy_par", 32'(busy), 0);
`endif
        if (!keep_en) enable = 1'b0;
        if (push) begin
            e.word = w;
            e.perr = PAR_EN && bad_par;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_word(input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        while (!valid && waited < 8) begin
            step();
            waited++;
        end
        check({tag, "_valid"}, 32'(valid), 1);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed=empty queue expected=pending word", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(data_out), 32'(e.word));
            check({tag, "_perr"}, 32'(parity_err), 32'(e.perr));
        end
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check({tag, "_ack"}, 32'(valid), 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [31:0] seq;

        reset_n     = 1'b0;
        data_in     = 1'b0;
        enable      = 1'b0;
        len         = LEN_W'(4);
        msb_first   = 1'b1;
        ack         = 1'b0;
        clr_overrun = 1'b0;
        step();
        step();
        check("rst_data", 32'(data_out), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(bit_cnt), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_perr", 32'(parity_err), 0);
        reset_n = 1'b1;
        step();

        // len=4, MSB-first, 1,0,1,1; config changed mid-frame must be ignored
        send_seq(32'b1101, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_word("msb4");
        do_ack("msb4");

        // same bits LSB-first
        send_seq(32'b1101, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("lsb4");
        do_ack("lsb4");

        // len=0 selects WIDTH: 0xA5C3 MSB-first
        v   = 16'hA5C3;
        seq = '0;
        for (int i = 0; i < 16; i++) seq[i] = v[15-i];
        send_seq(seq, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("len0");
        do_ack("len0");

        // len > WIDTH also selects WIDTH: 0x1234 LSB-first
        send_seq(32'h1234, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("len20");
        do_ack("len20");

        // back-to-back frames 0x3 then 0xC with no ack: second one dropped
        send_seq(32'b1100, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_seq(32'b0011, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_set", 32'(overrun), 1);
        expect_word("ovr");

        // overrun and clr_overrun on the same edge: set wins
        clr_overrun = 1'b1;
        send_seq(32'b1010, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_overrun = 1'b0;
        check("ovr_setwins", 32'(overrun), 1);
        check("ovr_hold_data", 32'(data_out), 32'h3);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 0);
        check("ovr_valid_kept", 32'(valid), 1);

        // ack on the completing edge: new word accepted, no overrun
        send_seq(32'b0110, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("simul_ovr", 32'(overrun), 0);
        expect_word("simul");
        do_ack("simul");

        // two bits, enable low for one cycle, then a full frame 0,0,0,1
        len       = LEN_W'(4);
        msb_first = 1'b1;
        enable    = 1'b1;
        data_in   = 1'b1;
        step();
        step();
        check("abort_cnt_pre", 32'(bit_cnt), 2);
        enable = 1'b0;
        step();
        check("abort_cnt", 32'(bit_cnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(valid), 0);
        send_seq(32'b1000, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("abort");
        do_ack("abort");

`ifdef S2P_PARITY_CHECK_EN
        send_seq(32'b1101, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("par_ok");
        do_ack("par_ok");
        send_seq(32'b1101, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_word("par_bad");
        // a dropped frame with good parity must not touch parity_err
        send_seq(32'b0001, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("par_drop_perr", 32'(parity_err), 1);
        check("par_drop_data", 32'(data_out), 32'hB);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        do_ack("par_bad");
`endif

        // build up valid + overrun + a partial frame, then reset asynchronously
        send_seq(32'b1001, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b0111, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_word("pre_rst");
        check("pre_rst_ovr", 32'(overrun), 1);
        len     = LEN_W'(4);
        enable  = 1'b1;
        data_in = 1'b1;
        step();
        step();
        check("pre_rst_cnt", 32'(bit_cnt), 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_out), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(bit_cnt), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        check("mid_rst_perr", 32'(parity_err), 0);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
